lc3_mem_responder: RTL and testbench
====================================

// Module: lc3_mem_responder
// PURPOSE
//  Responder end of the CPU memory interface driven by the LC-3 control unit (Mem_OE/Mem_WE).
//  Services multi-cycle reads/writes to an on-chip word RAM with fixed wait states.
//  Maps one I/O address: reads return switches, writes load the hex-display register.
//  Sits between the datapath MAR/MDR and the memory; the control FSM's fixed OE hold
//  (4 cycles) is the contract this block's read latency must meet.
// PARAMETERS
//  RD_WAIT     3        cycles from first OE cycle to Data_to_CPU valid; legal 2..7
//  WR_WAIT     2        cycles from first WE cycle to RAM commit edge; legal 1..7
//  DEPTH_LOG2  10       RAM depth = 2**DEPTH_LOG2 16-bit words
//  IO_ADDR     16'hFFFF memory-mapped switch/hex address
// PORTS
//  Clk           in   1   system clock, all state on rising edge
//  Reset         in   1   asynchronous, active-high
//  Mem_OE        in   1   read request, active-high, held for whole read
//  Mem_WE        in   1   write request, active-high, held for whole write
//  ADDR          in   16  word address (MAR)
//  Data_from_CPU in   16  write data (MDR)
//  SW            in   16  board switches, asynchronous
//  Data_to_CPU   out  16  registered read data
//  Mem_Ready     out  1   read data valid / write committed; level, held until request drops
//  Busy          out  1   1 in any non-IDLE state
//  Err           out  1   one-cycle pulse on illegal OE&WE request
//  HEX_Data      out  16  hex-display register
//  HEX_LD        out  1   one-cycle pulse when HEX_Data updated
// BEHAVIOUR
//  Reset: state IDLE, counter 0, all outputs 0 (HEX_Data 0). RAM contents NOT reset.
//  Reset mid-operation aborts it; a write not yet committed is lost.
//  Cycle 0 = first cycle a request is seen high in IDLE. ADDR/Data_from_CPU latched at end
//  of cycle 0; later changes ignored for that operation.
//  States: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE.
//  IDLE: OE&~WE -> RD_WAIT (cnt=1); WE&~OE -> WR_WAIT (cnt=1); OE&WE -> Err pulse
//   next cycle, stay IDLE, no access; neither -> IDLE.
//  RD_WAIT: RAM read issued at cycle 0 edge (sync-read, 1-cycle array latency).
//   Data_to_CPU loaded at end of cycle RD_WAIT-1; state RD_DONE in cycle RD_WAIT.
//   Latched address == IO_ADDR -> load 2-flop-synchronised SW instead of RAM data.
//  RD_DONE: Mem_Ready=1, Data_to_CPU held; OE low -> IDLE next edge (Mem_Ready drops).
//  WR_WAIT: commit on edge ending cycle WR_WAIT: RAM[addr] <= data, or for IO_ADDR
//   HEX_Data <= data and HEX_LD=1 in cycle WR_WAIT+1; then WR_DONE (Mem_Ready=1).
//  WR_DONE: WE low -> IDLE next edge.
//  Abort: request drops while in RD_WAIT/WR_WAIT -> IDLE next edge, no commit,
//   Mem_Ready never asserts, Data_to_CPU keeps previous value.
//  Request held >1 cycle after return to IDLE starts a new operation (back-to-back ok).
//  Address aliasing: non-IO addresses use ADDR[DEPTH_LOG2-1:0]; upper bits ignored.
//  Counter width 3 bits; saturates never (bounded by params). Data_to_CPU only changes
//  on read completion.
// STRUCTURE
//  Package lc3_mem_pkg: state enum mem_state_t, IO_ADDR default, WAIT limits.
//  Sub-module lc3_sram_array: single-port, sync write, sync read, no reset, DEPTH_LOG2 param.
//  Top: FSM + counter + address/data latches + SW synchroniser + HEX register.
// TESTING
//  1 Write 16'h1234 to 16'h0010 (WE 3 cyc) then read (OE 4 cyc) -> Mem_Ready cyc 3,
//    Data_to_CPU=16'h1234 in cyc 3, sampled correctly on OE cycle 4.
//  2 SW=16'hBEEF, read IO_ADDR -> Data_to_CPU=16'hBEEF; write 16'h00AB to IO_ADDR ->
//    HEX_Data=16'h00AB, HEX_LD single pulse, RAM[16'h03FF] unchanged.
//  3 Mem_OE=Mem_WE=1 in IDLE -> Err pulse 1 cycle, Busy=0, RAM/Data_to_CPU unchanged.
//  4 WE dropped in cycle 1 (WR_WAIT=2) -> no commit; later read of that addr returns old.
//  5 Reset asserted asynchronously in RD_WAIT -> outputs 0 same cycle, IDLE; prior
//    RAM contents intact on next read.
//  6 Write 16'h5555 to 16'h0401 (DEPTH_LOG2=10) -> read 16'h0001 returns 16'h5555;
//    ADDR changed during read -> data of latched address.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and limits for the LC-3 memory responder.
// Holds the FSM state encoding, the latched request payload and the wait-state bounds.
package lc3_mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 3;

  localparam logic [ADDR_W-1:0] IO_ADDR_DEFAULT = 16'hFFFF;

  localparam int unsigned RD_WAIT_MIN = 2;
  localparam int unsigned RD_WAIT_MAX = 7;
  localparam int unsigned WR_WAIT_MIN = 1;
  localparam int unsigned WR_WAIT_MAX = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_DONE,
    S_WR_WAIT,
    S_WR_DONE
  } mem_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  // Keeps an out-of-range wait-state parameter inside what the 3-bit counter can represent
  function automatic int unsigned clamp_wait(input int unsigned w, input int unsigned lo,
                                             input int unsigned hi);
    if (w < lo) return lo;
    if (w > hi) return hi;
    return w;
  endfunction

endpackage

// File: rtl/lc3_sram_array.sv
// Single-port word RAM: synchronous write, synchronous read-first, no reset.
module lc3_sram_array
  import lc3_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory responder for the LC-3 control unit: fixed wait-state reads/writes to on-chip RAM,
// plus one memory-mapped I/O word (switches on read, hex display register on write).
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int unsigned       RD_WAIT    = 3,
  parameter int unsigned       WR_WAIT    = 2,
  parameter int unsigned       DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] IO_ADDR    = IO_ADDR_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_from_CPU,
  input  logic [DATA_W-1:0] SW,
  output logic [DATA_W-1:0] Data_to_CPU,
  output logic              Mem_Ready,
  output logic              Busy,
  output logic              Err,
  output logic [DATA_W-1:0] HEX_Data,
  output logic              HEX_LD
);

  localparam int unsigned RD_W = clamp_wait(RD_WAIT, RD_WAIT_MIN, RD_WAIT_MAX);
  localparam int unsigned WR_W = clamp_wait(WR_WAIT, WR_WAIT_MIN, WR_WAIT_MAX);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] hex_q, hex_d;
  logic              hex_ld_q, hex_ld_d;
  logic              err_q, err_d;
  logic              ready_q, busy_q;
  logic [DATA_W-1:0] sw_meta_q, sw_sync_q;

  logic                  ram_we_c;
  logic [DEPTH_LOG2-1:0] ram_addr_c;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  req_is_io_c;

  lc3_sram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we_c),
    .addr_i  (ram_addr_c),
    .wdata_i (req_q.data),
    .rdata_o (ram_rdata)
  );

  assign req_is_io_c = (req_q.addr == IO_ADDR);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    hex_d    = hex_q;
    hex_ld_d = 1'b0;
    err_d    = 1'b0;
    ram_we_c = 1'b0;
    // In IDLE the live address feeds the array so cycle-0 reads start at once
    ram_addr_c = (state_q == S_IDLE) ? ADDR[DEPTH_LOG2-1:0] : req_q.addr[DEPTH_LOG2-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (Mem_OE && Mem_WE) begin
          err_d = 1'b1;
        end else if (Mem_OE || Mem_WE) begin
          req_d   = '{addr: ADDR, data: Data_from_CPU};
          cnt_d   = CNT_W'(1);
          state_d = Mem_OE ? S_RD_WAIT : S_WR_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (!Mem_OE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(RD_W - 1)) begin
          rdata_d = req_is_io_c ? sw_sync_q : ram_rdata;
          state_d = S_RD_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_DONE: begin
        if (!Mem_OE) state_d = S_IDLE;
      end
      S_WR_WAIT: begin
        if (!Mem_WE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(WR_W)) begin
          if (req_is_io_c) begin
            hex_d    = req_q.data;
            hex_ld_d = 1'b1;
          end else begin
            ram_we_c = 1'b1;
          end
          state_d = S_WR_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_DONE: begin
        if (!Mem_WE) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      rdata_q   <= '0;
      hex_q     <= '0;
      hex_ld_q  <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      hex_q     <= hex_d;
      hex_ld_q  <= hex_ld_d;
      err_q     <= err_d;
      ready_q   <= (state_d == S_RD_DONE) || (state_d == S_WR_DONE);
      busy_q    <= (state_d != S_IDLE);
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign Data_to_CPU = rdata_q;
  assign Mem_Ready   = ready_q;
  assign Busy        = busy_q;
  assign Err         = err_q;
  assign HEX_Data    = hex_q;
  assign HEX_LD      = hex_ld_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: transaction-level timing model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_lc3_mem_responder;

  localparam int RW = 3;
  localparam int WW = 2;
  localparam logic [15:0] IOA = 16'hFFFF;

  logic        Clk = 1'b0;
  logic        Reset, Mem_OE, Mem_WE;
  logic [15:0] ADDR, Data_from_CPU, SW;
  logic [15:0] Data_to_CPU, HEX_Data;
  logic        Mem_Ready, Busy, Err, HEX_LD;

  lc3_mem_responder #(.RD_WAIT(RW), .WR_WAIT(WW), .DEPTH_LOG2(10), .IO_ADDR(IOA)) dut (
    .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
    .Data_from_CPU(Data_from_CPU), .SW(SW), .Data_to_CPU(Data_to_CPU),
    .Mem_Ready(Mem_Ready), .Busy(Busy), .Err(Err), .HEX_Data(HEX_Data), .HEX_LD(HEX_LD)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl_mem [0:1023];
  logic [15:0] exp_data, exp_hex;
  logic        exp_ready, exp_busy, exp_err, exp_hexld;
  bit          chk_en = 0;
  logic [15:0] snap_data;
  logic        snap_ready;

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check16("Data_to_CPU", Data_to_CPU, exp_data);
      check1("Mem_Ready", Mem_Ready, exp_ready);
      check1("Busy", Busy, exp_busy);
      check1("Err", Err, exp_err);
      check16("HEX_Data", HEX_Data, exp_hex);
      check1("HEX_LD", HEX_LD, exp_hexld);
    end
  end

  // kind: 0 read, 1 write, 2 simultaneous OE&WE. hold = cycles request stays high.
  task automatic run_op(input int kind, input logic [15:0] a, input logic [15:0] d,
                        input int hold, input logic [15:0] a_late);
    bit complete, io;
    int done_start, done_end, last;
    io = (a == IOA);
    if (kind == 0) begin
      complete   = (hold >= RW);
      done_start = RW;
      done_end   = (hold > RW) ? hold : RW;
    end else if (kind == 1) begin
      complete   = (hold >= WW + 1);
      done_start = WW + 1;
      done_end   = (hold > WW + 1) ? hold : WW + 1;
    end else begin
      complete   = 0;
      done_start = 0;
      done_end   = 0;
      hold       = 1;
    end
    last = complete ? done_end : hold;
    for (int c = 0; c <= last + 1; c++) begin
      @(posedge Clk);
      #1;
      Mem_OE        = (kind != 1) && (c < hold);
      Mem_WE        = (kind != 0) && (c < hold);
      ADDR          = (c == 0) ? a : a_late;
      Data_from_CPU = (c == 0) ? d : ~d;
      exp_err   = (kind == 2) && (c == 1);
      exp_busy  = (kind != 2) && (c >= 1) && (c <= last);
      exp_ready = complete && (c >= done_start) && (c <= done_end);
      exp_hexld = (kind == 1) && complete && io && (c == WW + 1);
      if (kind == 1 && complete && c == WW + 1) begin
        if (io) exp_hex = d;
        else    mdl_mem[a[9:0]] = d;
      end
      if (kind == 0 && complete && c == RW) exp_data = io ? SW : mdl_mem[a[9:0]];
      if (c == RW) begin
        snap_data  = Data_to_CPU;
        snap_ready = Mem_Ready;
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0;
    ADDR = '0; Data_from_CPU = '0; SW = 16'hBEEF;
    exp_data = '0; exp_hex = '0;
    exp_ready = 0; exp_busy = 0; exp_err = 0; exp_hexld = 0;
    repeat (3) @(posedge Clk);
    #1;
    check16("rst_data", Data_to_CPU, 16'h0000);
    check1("rst_ready", Mem_Ready, 1'b0);
    check1("rst_busy", Busy, 1'b0);
    check1("rst_err", Err, 1'b0);
    check16("rst_hex", HEX_Data, 16'h0000);
    check1("rst_hexld", HEX_LD, 1'b0);
    Reset = 1'b0;
    chk_en = 1;

    // 1: write then read back, OE held 4 cycles
    run_op(1, 16'h0010, 16'h1234, 3, 16'h0011);
    run_op(0, 16'h0010, 16'h0000, 4, 16'h0011);
    check16("t1_data_cyc3", snap_data, 16'h1234);
    check1("t1_ready_cyc3", snap_ready, 1'b1);

    // 2: switch read, hex write, aliased RAM word untouched
    run_op(1, 16'h03FF, 16'h7777, 3, 16'h03FF);
    run_op(0, IOA, 16'h0000, 4, 16'h0000);
    check16("t2_sw_read", Data_to_CPU, 16'hBEEF);
    run_op(1, IOA, 16'h00AB, 3, 16'h0000);
    check16("t2_hex", HEX_Data, 16'h00AB);
    run_op(0, 16'h03FF, 16'h0000, 3, 16'h0000);
    check16("t2_ram3ff", Data_to_CPU, 16'h7777);

    // 3: illegal simultaneous request
    run_op(2, 16'h0010, 16'hDEAD, 1, 16'h0010);
    check16("t3_data_kept", Data_to_CPU, 16'h7777);
    run_op(0, 16'h0010, 16'h0000, 3, 16'h0010);
    check16("t3_ram_kept", Data_to_CPU, 16'h1234);

    // 4: write aborted in cycle 1, then a read aborted mid-wait
    run_op(1, 16'h0020, 16'h1111, 3, 16'h0020);
    run_op(1, 16'h0020, 16'h2222, 1, 16'h0020);
    run_op(0, 16'h0010, 16'h0000, 2, 16'h0010);
    run_op(0, 16'h0020, 16'h0000, 3, 16'h0020);
    check16("t4_no_commit", Data_to_CPU, 16'h1111);

    // 5: asynchronous reset during RD_WAIT
    chk_en = 0;
    @(posedge Clk); #1;
    Mem_OE = 1'b1; ADDR = 16'h0010;
    @(posedge Clk); #3;
    Reset = 1'b1;
    #1;
    check16("t5_data0", Data_to_CPU, 16'h0000);
    check1("t5_busy0", Busy, 1'b0);
    check1("t5_ready0", Mem_Ready, 1'b0);
    check16("t5_hex0", HEX_Data, 16'h0000);
    Mem_OE = 1'b0;
    exp_data = '0; exp_hex = '0;
    exp_ready = 0; exp_busy = 0; exp_err = 0; exp_hexld = 0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    chk_en = 1;
    run_op(0, 16'h0010, 16'h0000, 3, 16'h0010);
    check16("t5_ram_intact", Data_to_CPU, 16'h1234);

    // 6: address aliasing and address latching
    run_op(1, 16'h0401, 16'h5555, 3, 16'h0002);
    run_op(0, 16'h0001, 16'h0000, 4, 16'h0020);
    check16("t6_alias", Data_to_CPU, 16'h5555);
    run_op(0, 16'h0401, 16'h0000, 5, 16'h0010);
    check16("t6_latched", Data_to_CPU, 16'h5555);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
